sdram_port_arbiter: RTL and testbench

SDRAM_PORT_ARBITER -- requirements
Module: sdram_port_arbiter

---
 rtl/sdram_port_arbiter.sv | 175 +++++++++++++++++
 tb/tb_sdram_port_arbiter.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_port_arbiter.sv
// Three-port arbiter in front of a single-request SDRAM controller.
// Ports: clk/resetn; p0..p2 valid/addr/din/wmask in, ready/rdata out;
// mem_valid/addr/din/wmask out, mem_ready/dout in; gnt one-hot out.
// Macro SDRAM_ARB_RR_EN selects round-robin instead of fixed priority.
module sdram_port_arbiter #(
  parameter int ADDR_W = 25,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              p0_valid,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_din,
  input  logic [3:0]        p0_wmask,
  output logic              p0_ready,
  output logic [DATA_W-1:0] p0_rdata,
  input  logic              p1_valid,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_din,
  input  logic [3:0]        p1_wmask,
  output logic              p1_ready,
  output logic [DATA_W-1:0] p1_rdata,
  input  logic              p2_valid,
  input  logic [ADDR_W-1:0] p2_addr,
  input  logic [DATA_W-1:0] p2_din,
  input  logic [3:0]        p2_wmask,
  output logic              p2_ready,
  output logic [DATA_W-1:0] p2_rdata,
  output logic              mem_valid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  output logic [3:0]        mem_wmask,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_dout,
  output logic [2:0]        gnt
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RELEASE
  } state_t;

  state_t state, state_nx;

  logic [2:0]        req;
  logic [2:0]        pick;
  logic              load;
  logic              busy;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_din;
  logic [3:0]        sel_wmask;

  assign req  = {p2_valid, p1_valid, p0_valid};
  assign busy = (state == BUSY);

  assign mem_valid = busy;

  // Ready is gated by resetn so a completion that races reset is dropped.
  assign p0_ready = resetn & busy & mem_ready & gnt[0];
  assign p1_ready = resetn & busy & mem_ready & gnt[1];
  assign p2_ready = resetn & busy & mem_ready & gnt[2];

  assign p0_rdata = mem_dout;
  assign p1_rdata = mem_dout;
  assign p2_rdata = mem_dout;

`ifdef SDRAM_ARB_RR_EN
  // Index of the last granted port; search starts one past it.
  logic [1:0] ptr_q;
  logic [1:0] ptr_nx;

  always_comb begin
    pick = 3'b000;
    unique case (ptr_q)
      2'd0: begin
        if (req[1])      pick = 3'b010;
        else if (req[2]) pick = 3'b100;
        else if (req[0]) pick = 3'b001;
      end
      2'd1: begin
        if (req[2])      pick = 3'b100;
        else if (req[0]) pick = 3'b001;
        else if (req[1]) pick = 3'b010;
      end
      default: begin
        if (req[0])      pick = 3'b001;
        else if (req[1]) pick = 3'b010;
        else if (req[2]) pick = 3'b100;
      end
    endcase
  end

  always_comb begin
    ptr_nx = 2'd0;
    if (pick[1])      ptr_nx = 2'd1;
    else if (pick[2]) ptr_nx = 2'd2;
  end

  always_ff @(posedge clk) begin
    if (!resetn)
      ptr_q <= 2'd2;
    else if (load)
      ptr_q <= ptr_nx;
  end
`else
  always_comb begin
    pick = 3'b000;
    priority case (1'b1)
      req[0]:  pick = 3'b001;
      req[1]:  pick = 3'b010;
      req[2]:  pick = 3'b100;
      default: pick = 3'b000;
    endcase
  end
`endif

  always_comb begin
    sel_addr  = p0_addr;
    sel_din   = p0_din;
    sel_wmask = p0_wmask;
    unique case (1'b1)
      pick[1]: begin
        sel_addr  = p1_addr;
        sel_din   = p1_din;
        sel_wmask = p1_wmask;
      end
      pick[2]: begin
        sel_addr  = p2_addr;
        sel_din   = p2_din;
        sel_wmask = p2_wmask;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_nx = state;
    load     = 1'b0;
    unique case (state)
      IDLE: begin
        if (|req) begin
          state_nx = BUSY;
          load     = 1'b1;
        end
      end
      BUSY: begin
        if (mem_ready) state_nx = RELEASE;
      end
      RELEASE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= IDLE;
      gnt       <= 3'b000;
      mem_addr  <= '0;
      mem_din   <= '0;
      mem_wmask <= 4'h0;
    end else begin
      state <= state_nx;
      if (load) begin
        gnt       <= pick;
        mem_addr  <= sel_addr;
        mem_din   <= sel_din;
        mem_wmask <= sel_wmask;
      end else if (busy && mem_ready) begin
        gnt <= 3'b000;
      end
    end
  end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Scoreboard bench for sdram_port_arbiter.
// Expected ready/rdata events are queued; a negedge monitor checks them.
module tb_sdram_port_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        p0_valid, p1_valid, p2_valid;
  logic [24:0] p0_addr, p1_addr, p2_addr;
  logic [31:0] p0_din, p1_din, p2_din;
  logic [3:0]  p0_wmask, p1_wmask, p2_wmask;
  logic        p0_ready, p1_ready, p2_ready;
  logic [31:0] p0_rdata, p1_rdata, p2_rdata;
  logic        mem_valid;
  logic [24:0] mem_addr;
  logic [31:0] mem_din;
  logic [3:0]  mem_wmask;
  logic        mem_ready;
  logic [31:0] mem_dout;
  logic [2:0]  gnt;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          port;
    logic [31:0] data;
  } exp_t;

  exp_t sbq[$];

  always #5 clk = ~clk;

  sdram_port_arbiter dut (
    .clk(clk), .resetn(resetn),
    .p0_valid(p0_valid), .p0_addr(p0_addr), .p0_din(p0_din),
    .p0_wmask(p0_wmask), .p0_ready(p0_ready), .p0_rdata(p0_rdata),
    .p1_valid(p1_valid), .p1_addr(p1_addr), .p1_din(p1_din),
    .p1_wmask(p1_wmask), .p1_ready(p1_ready), .p1_rdata(p1_rdata),
    .p2_valid(p2_valid), .p2_addr(p2_addr), .p2_din(p2_din),
    .p2_wmask(p2_wmask), .p2_ready(p2_ready), .p2_rdata(p2_rdata),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_wmask(mem_wmask), .mem_ready(mem_ready),
    .mem_dout(mem_dout), .gnt(gnt)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sb_push(input int port, input logic [31:0] d);
    exp_t e;
    e.port = port;
    e.data = d;
    sbq.push_back(e);
  endtask

  // Monitor: every ready pulse must match the oldest expected event.
  always @(negedge clk) begin
    logic [2:0]  r;
    logic [31:0] rd [3];
    exp_t        e;
    r = {p2_ready, p1_ready, p0_ready};
    rd[0] = p0_rdata;
    rd[1] = p1_rdata;
    rd[2] = p2_rdata;
    for (int k = 0; k < 3; k++) begin
      if (r[k]) begin
        checks++;
        if (sbq.size() == 0) begin
          errors++;
          $display("FAIL spurious_ready port=%0d actual=1 required=0", k);
        end else begin
          e = sbq.pop_front();
          if (e.port != k || rd[k] !== e.data) begin
            errors++;
            $display("FAIL ready_event actual=p%0d/%h required=p%0d/%h",
                     k, rd[k], e.port, e.data);
          end
        end
      end
    end
  end

  // Wait (bounded) for a request, check the grant, then complete it.
  task automatic serve(input int port, input logic [31:0] d);
    int n;
    n = 0;
    @(negedge clk);
    while (!mem_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("serve_valid", 32'(mem_valid), 32'd1);
    chk("serve_gnt", 32'(gnt), 32'(3'b001 << port));
    step();
    mem_ready = 1'b1;
    mem_dout  = d;
    if (mem_valid) sb_push(port, d);
    step();
    mem_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int order [6];
`ifdef SDRAM_ARB_RR_EN
    order = '{0, 1, 2, 0, 1, 2};
`else
    order = '{0, 0, 0, 0, 0, 0};
`endif
    resetn    = 1'b0;
    p0_valid  = 0; p1_valid = 0; p2_valid = 0;
    p0_addr   = '0; p1_addr = '0; p2_addr = '0;
    p0_din    = '0; p1_din = '0; p2_din = '0;
    p0_wmask  = '0; p1_wmask = '0; p2_wmask = '0;
    mem_ready = 0;
    mem_dout  = '0;
    step();
    step();
    @(negedge clk);
    chk("rst_mem_valid", 32'(mem_valid), 32'd0);
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_din", mem_din, 32'd0);
    chk("rst_mem_wmask", 32'(mem_wmask), 32'd0);

    // Spurious mem_ready while idle.
    step();
    resetn    = 1'b1;
    mem_ready = 1'b1;
    mem_dout  = 32'h0BADF00D;
    @(negedge clk);
    chk("idle_ready", 32'({p2_ready, p1_ready, p0_ready}), 32'd0);
    step();
    mem_ready = 1'b0;
    @(negedge clk);
    chk("idle_gnt", 32'(gnt), 32'd0);
    chk("idle_valid", 32'(mem_valid), 32'd0);

    // Single read from p1.
    step();
    p1_valid = 1'b1;
    p1_addr  = 25'h0000100;
    p1_wmask = 4'h0;
    step();
    p1_valid = 1'b0;
    p1_addr  = 25'h1FFFFFF;
    @(negedge clk);
    chk("rd_gnt", 32'(gnt), 32'b010);
    chk("rd_valid", 32'(mem_valid), 32'd1);
    chk("rd_addr", 32'(mem_addr), 32'h0000100);
    chk("rd_wmask", 32'(mem_wmask), 32'd0);
    step();
    mem_ready = 1'b1;
    mem_dout  = 32'hDEADBEEF;
    sb_push(1, 32'hDEADBEEF);
    step();
    mem_ready = 1'b0;
    @(negedge clk);
    chk("rel_valid", 32'(mem_valid), 32'd0);
    chk("rel_gnt", 32'(gnt), 32'd0);
    step();

    // Write data latched and held while p0 changes its inputs.
    p0_valid = 1'b1;
    p0_addr  = 25'h0000200;
    p0_din   = 32'h12345678;
    p0_wmask = 4'hF;
    step();
    p0_valid = 1'b0;
    p0_din   = 32'h0;
    p0_wmask = 4'h0;
    @(negedge clk);
    chk("wr_gnt", 32'(gnt), 32'b001);
    chk("wr_din", mem_din, 32'h12345678);
    chk("wr_wmask", 32'(mem_wmask), 32'hF);
    step();
    @(negedge clk);
    chk("wr_din_hold", mem_din, 32'h12345678);
    chk("wr_addr_hold", 32'(mem_addr), 32'h0000200);
    step();
    mem_ready = 1'b1;
    mem_dout  = 32'hCAFEF00D;
    sb_push(0, 32'hCAFEF00D);
    step();
    mem_ready = 1'b0;
    step();

    // Contention with all three ports requesting continuously.
    p0_valid = 1'b1;
    p1_valid = 1'b1;
    p2_valid = 1'b1;
    for (int i = 0; i < 6; i++)
      serve(order[i], 32'hA000_0000 + 32'(i));
    p0_valid = 1'b0;
    p1_valid = 1'b0;
    p2_valid = 1'b0;
    step();
    step();
    step();

    // Back-to-back: p2 still pending after its own completion.
    p2_valid = 1'b1;
    serve(2, 32'hB0B0_0001);
    @(negedge clk);
    chk("b2b_m1_valid", 32'(mem_valid), 32'd0);
    step();
    @(negedge clk);
    chk("b2b_m2_valid", 32'(mem_valid), 32'd0);
    step();
    @(negedge clk);
    chk("b2b_m3_valid", 32'(mem_valid), 32'd1);
    chk("b2b_m3_gnt", 32'(gnt), 32'b100);
    p2_valid = 1'b0;
    serve(2, 32'hB0B0_0002);
    step();
    step();

    // Reset in BUSY with mem_ready inside the reset window.
    p0_valid = 1'b1;
    step();
    @(negedge clk);
    chk("mid_gnt", 32'(gnt), 32'b001);
    step();
    resetn    = 1'b0;
    mem_ready = 1'b1;
    mem_dout  = 32'hFFFF0000;
    p1_valid  = 1'b1;
    p2_valid  = 1'b1;
    @(negedge clk);
    chk("mid_rst_ready", 32'({p2_ready, p1_ready, p0_ready}), 32'd0);
    step();
    @(negedge clk);
    chk("mid_rst_ready2", 32'({p2_ready, p1_ready, p0_ready}), 32'd0);
    chk("mid_rst_valid", 32'(mem_valid), 32'd0);
    chk("mid_rst_gnt", 32'(gnt), 32'd0);
    step();
    mem_ready = 1'b0;
    resetn    = 1'b1;
    serve(0, 32'h5A5A5A5A);
    p0_valid = 1'b0;
    p1_valid = 1'b0;
    p2_valid = 1'b0;
    step();
    step();
    step();
    step();
    chk("sb_empty", 32'(sbq.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
